// File: rtl/result_wb_queue_pkg.sv
// Shared types and helpers for the integer result writeback path.
// RES_UOp/BranchProv mirror the core-wide definitions; sqn_younger is shared with other stages.
package result_wb_queue_pkg;

  localparam int unsigned SQN_W                = 8;
  localparam int unsigned TAG_W                = 7;
  localparam int unsigned DATA_W               = 32;
  localparam int unsigned FLAGS_W              = 4;
  localparam int unsigned PC_W                 = 32;
  localparam int unsigned DEFAULT_DEPTH        = 4;
  localparam int unsigned DEFAULT_STALL_MARGIN = 2;

  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [TAG_W-1:0]   tagDst;
    SqN                 sqN;
    logic [FLAGS_W-1:0] flags;
    logic               doNotCommit;
    logic               valid;
  } RES_UOp;

  typedef struct packed {
    logic [PC_W-1:0] dstPC;
    SqN              sqN;
    logic            taken;
  } BranchProv;

  localparam int unsigned RES_UOP_W    = $bits(RES_UOp);
  localparam int unsigned BRANCH_PRV_W = $bits(BranchProv);

  // True when a is strictly younger than b; the signed difference tolerates sqN wrap-around.
  function automatic logic sqn_younger(input SqN a, input SqN b);
    SqN diff;
    diff = a - b;
    return $signed(diff) > $signed(SqN'(0));
  endfunction

endpackage

// File: rtl/result_wb_queue.sv
// In-order result buffer between an integer execution unit and the shared writeback port.
// Buffered results younger than a taken branch are invalidated in place and skipped on pop.
module result_wb_queue
  import result_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned STALL_MARGIN = DEFAULT_STALL_MARGIN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RES_UOP_W-1:0]      IN_uop,
  input  logic [BRANCH_PRV_W-1:0]   IN_branch,
  input  logic                      IN_wbReady,
  output logic [RES_UOP_W-1:0]      OUT_uop,
  output logic                      OUT_stall,
  output logic [$clog2(DEPTH):0]    OUT_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  RES_UOp     inUop;
  BranchProv  br;
  RES_UOp     outUop;
  RES_UOp     outNext;
  RES_UOp     mem [DEPTH];

  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtrNext;
  logic [PTR_W-1:0] wrPtrNext;
  logic [PTR_W-1:0] occNext;
  logic [PTR_W-1:0] countNext;
  logic [IDX_W-1:0] rdIdx;
  logic [IDX_W-1:0] wrIdx;
  logic [DEPTH-1:0] memKill;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             inKill;
  logic             inOk;
  logic             outKill;
  logic             outLoadable;
  logic             doPop;
  logic             doEnq;
  logic             stallNext;
  logic             unusedDstPC;

  assign inUop       = IN_uop;
  assign br          = IN_branch;
  assign OUT_uop     = outUop;
  assign unusedDstPC = ^br.dstPC;

  function automatic logic killedBy(input BranchProv b, input SqN s);
    return b.taken && sqn_younger(s, b.sqN);
  endfunction

  // Flush detection, output-register reload and pointer/occupancy next state.
  always_comb begin
    outNext   = outUop;
    doPop     = 1'b0;
    doEnq     = 1'b0;
    rdIdx     = rdPtr[IDX_W-1:0];
    wrIdx     = wrPtr[IDX_W-1:0];
    fifoEmpty = (wrPtr == rdPtr);
    fifoFull  = (wrPtr[IDX_W-1:0] == rdPtr[IDX_W-1:0]) && (wrPtr[IDX_W] != rdPtr[IDX_W]);

    for (int i = 0; i < DEPTH; i++) begin
      memKill[i] = killedBy(br, mem[i].sqN);
    end

    inKill      = killedBy(br, inUop.sqN);
    inOk        = inUop.valid && !inKill;
    outKill     = killedBy(br, outUop.sqN);
    outLoadable = !outUop.valid || IN_wbReady || outKill;

    if (outLoadable) begin
      if (!fifoEmpty) begin
        // A hole or a freshly killed head still pops, leaving the register empty.
        doPop         = 1'b1;
        outNext       = mem[rdIdx];
        outNext.valid = mem[rdIdx].valid && !memKill[rdIdx];
      end else begin
        outNext       = inUop;
        outNext.valid = inOk;
      end
    end

    doEnq     = inOk && !fifoFull && !(fifoEmpty && outLoadable);
    rdPtrNext = rdPtr + PTR_W'(doPop);
    wrPtrNext = wrPtr + PTR_W'(doEnq);
    occNext   = wrPtrNext - rdPtrNext;
    countNext = occNext + PTR_W'(outNext.valid);
    stallNext = (DEPTH - 32'(occNext)) <= STALL_MARGIN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      outUop    <= '0;
      OUT_stall <= 1'b0;
      OUT_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      rdPtr     <= rdPtrNext;
      wrPtr     <= wrPtrNext;
      outUop    <= outNext;
      OUT_stall <= stallNext;
      OUT_count <= countNext;
      for (int i = 0; i < DEPTH; i++) begin
        if (memKill[i]) begin
          mem[i].valid <= 1'b0;
        end
      end
      if (doEnq) begin
        mem[wrIdx] <= inUop;
      end
    end
  end

  // The issue stage must honour OUT_stall; a result arriving while full would be lost.
  assert property (@(posedge clk) disable iff (!rst) !(inUop.valid && fifoFull));

endmodule
